// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
//
// VGA raster scan controller. A 2-bit divider turns the 100 MHz system clock
// into a 25 MHz pixel tick. Horizontal/vertical counters walk the full raster
// (active + porches + sync). Scaled VRAM cell indices are kept with small
// sub-counters, so no divider or multiplier is needed for address generation.
// The shared VRAM read address is {row_idx, col_idx}. VRAM data, the
// active-area flag and both sync levels are loaded into the output registers
// together, two clocks after each counter update.
//
// Ports:
//   clk         system clock (100 MHz)
//   reset       asynchronous reset, active-low
//   vram_red    read data from the red VRAM (1 bit)
//   vram_green  read data from the green VRAM (1 bit)
//   vram_blue   read data from the blue VRAM (1 bit)
//   vram_addr   shared VRAM read address {row_idx[6:0], col_idx[6:0]}
//   vga_red     4-bit colour to DAC
//   vga_green   4-bit colour to DAC
//   vga_blue    4-bit colour to DAC
//   hsync       horizontal sync, active-low
//   vsync       vertical sync, active-low
//
// Build option:
//   VGA_TEST_PATTERN_EN  when defined, the active area shows a checkerboard
//                        (col_idx[3] ^ row_idx[3]) and VRAM data is ignored.
//                        Sync timing and address generation are unchanged.
// ---------------------------------------------------------------------------
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vram_red,
  input  logic        vram_green,
  input  logic        vram_blue,
  output logic [13:0] vram_addr,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic        hsync,
  output logic        vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);

  logic [1:0]    div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [SW-1:0] hsub;
  logic [SW-1:0] vsub;
  logic [6:0]    col_idx;
  logic [6:0]    row_idx;

  logic tick;
  logic load;
  logic h_wrap;
  logic v_wrap;
  logic line_adv;
  logic h_step;
  logic v_step;
  logic active;
  logic in_hsync;
  logic in_vsync;
  logic pix_red;
  logic pix_green;
  logic pix_blue;

  // Counters advance on tick (div==3); outputs load two clocks later (div==1),
  // which leaves one clock for the synchronous VRAM read in between.
  assign tick     = (div == 2'd3);
  assign load     = (div == 2'd1);
  assign h_wrap   = (hcnt == H_LAST);
  assign v_wrap   = (vcnt == V_LAST);
  assign line_adv = tick && h_wrap;

  // Cell indices only step while the next count is still inside the visible
  // area, so the address holds its last visible value through the blanking.
  assign h_step   = (hcnt < H_ACT_LAST);
  assign v_step   = (vcnt < V_ACT_LAST);

  assign active   = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign in_hsync = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
  assign in_vsync = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);

  assign vram_addr = {row_idx, col_idx};

`ifdef VGA_TEST_PATTERN_EN
  // Checkerboard of 8x8 cells; all channels share the same level.
  assign pix_red   = col_idx[3] ^ row_idx[3];
  assign pix_green = col_idx[3] ^ row_idx[3];
  assign pix_blue  = col_idx[3] ^ row_idx[3];
`else
  assign pix_red   = vram_red;
  assign pix_green = vram_green;
  assign pix_blue  = vram_blue;
`endif

  // Free-running pixel-clock divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= 2'd0;
    end else begin
      div <= div + 2'd1;
    end
  end

  // Horizontal pixel counter with its cell sub-counter and column index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt    <= '0;
      hsub    <= '0;
      col_idx <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        hcnt    <= '0;
        hsub    <= '0;
        col_idx <= '0;
      end else begin
        hcnt <= hcnt + 1'b1;
        if (h_step) begin
          if (hsub == SUB_LAST) begin
            hsub    <= '0;
            col_idx <= col_idx + 7'd1;
          end else begin
            hsub <= hsub + 1'b1;
          end
        end
      end
    end
  end

  // Vertical line counter with its cell sub-counter and row index; steps
  // once per line, on the tick where the horizontal counter wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcnt    <= '0;
      vsub    <= '0;
      row_idx <= '0;
    end else if (line_adv) begin
      if (v_wrap) begin
        vcnt    <= '0;
        vsub    <= '0;
        row_idx <= '0;
      end else begin
        vcnt <= vcnt + 1'b1;
        if (v_step) begin
          if (vsub == SUB_LAST) begin
            vsub    <= '0;
            row_idx <= row_idx + 7'd1;
          end else begin
            vsub <= vsub + 1'b1;
          end
        end
      end
    end
  end

  // Colour and sync are all taken from the same counter snapshot in one
  // load so they can never skew against each other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_red   <= 4'h0;
      vga_green <= 4'h0;
      vga_blue  <= 4'h0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else if (load) begin
      hsync     <= ~in_hsync;
      vsync     <= ~in_vsync;
      vga_red   <= active ? {4{pix_red}}   : 4'h0;
      vga_green <= active ? {4{pix_green}} : 4'h0;
      vga_blue  <= active ? {4{pix_blue}}  : 4'h0;
    end
  end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal porch and sync widths in pixels.
REQ-004 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-005 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical porch and sync widths in lines.
REQ-006 Parameter SCALE, default 5: screen pixels per VRAM cell, applied in both axes.
REQ-007 clk  input  1  system clock, 100 MHz.
REQ-008 reset  input  1  asynchronous reset, active-low.
REQ-009 vram_red / vram_green / vram_blue  input  1 each  read data from the three colour VRAMs.
REQ-010 vram_addr  output  14  shared read address to all three VRAMs, {row_idx[6:0], col_idx[6:0]}.
REQ-011 vga_red / vga_green / vga_blue  output  4 each  colour to DAC.
REQ-012 hsync / vsync  output  1 each  sync pulses, active-low.

Function
REQ-013 A 2-bit divider SHALL count 0..3 every clk; pixel tick is asserted when the divider equals 3, giving a 25 MHz pixel rate.
REQ-014 hcnt SHALL count 0..799 on each tick and wrap to 0; vcnt SHALL advance on each tick where hcnt wraps, counting 0..524 before wrapping to 0.
REQ-015 Sub-counter hsub SHALL count 0..SCALE-1 with hcnt; col_idx SHALL increment when hsub wraps; both SHALL clear when hcnt wraps.
REQ-016 Sub-counter vsub and row_idx SHALL follow the same rules on line advance; both SHALL clear when vcnt wraps.
REQ-017 No divider or multiplier SHALL be used for address generation.
REQ-018 vram_addr SHALL be driven from the registered row_idx/col_idx; outside the active area it holds the last value, and no read is ever suppressed.
REQ-019 VRAM read latency is 1 clk. Output registers SHALL load on the edge where the divider equals 1, so data and sync for a pixel appear 2 clk after its counter update.
REQ-020 Active area is hcnt<H_ACTIVE and vcnt<V_ACTIVE; inside it each 4-bit colour output SHALL be its VRAM bit replicated ×4; outside it all colour outputs SHALL be 0.
REQ-021 hsync SHALL be 0 for hcnt in [656,751] and 1 otherwise.
REQ-022 vsync SHALL be 0 for vcnt in [490,491] and 1 otherwise.
REQ-023 hsync, vsync and colour outputs SHALL be loaded from the same counter snapshot, so they never skew relative to each other.
REQ-024 At the frame corner (hcnt=799, vcnt=524), all counters, sub-counters and indices SHALL wrap to 0 on the same tick.

Reset
REQ-025 While reset=0, the following SHALL be held: divider, hcnt, vcnt, hsub, vsub, col_idx, row_idx = 0; vram_addr = 0; colour outputs = 0; hsync = vsync = 1.
REQ-026 Reset asserted mid-frame SHALL take effect immediately without waiting for a clock edge.
REQ-027 After reset releases, the first tick SHALL occur on the 4th rising edge; the frame then restarts at pixel (0,0).

Configuration
REQ-028 Macro VGA_TEST_PATTERN_EN.
- Defined: active-area colour SHALL be a checkerboard, all channels = 4'hF when col_idx[3]^row_idx[3]=1, else 0. VRAM inputs are ignored; vram_addr still counts.
- Undefined: colour SHALL come from the VRAMs per REQ-020.
- Sync timing is identical in both builds.

Verification
REQ-029 Release reset, run 1 frame -> hsync low for exactly 384 clk per line, line period 3200 clk, vsync low for exactly 6400 clk, frame period 1 680 000 clk.
REQ-030 VRAM model returns blue=1 only at address 129 -> vga_blue=4'hF exactly for hcnt 5..9 on vcnt 5..9, vga_red=vga_green=0 everywhere.
REQ-031 Sample vram_addr at hcnt=639, vcnt=479 -> 14'h2FFF (row 95, col 127); at hcnt=0, vcnt=0 of next frame -> 14'h0000.
REQ-032 All VRAM bits=1 -> colour outputs 4'hF only inside the active area and 0 during the porch/sync regions of both axes.
REQ-033 Assert reset at hcnt=300, vcnt=200 without clock alignment -> outputs reach reset values in the same cycle; after release the next frame starts at (0,0) with correct sync timing.
REQ-034 Build with VGA_TEST_PATTERN_EN, VRAM inputs tied 0 -> pixel (0,0) is black, pixel (40,0) is 4'hF on all channels (col_idx=8), sync timing unchanged.
